imem_loader: RTL

Byte-stream instruction-memory writer for the RISC-8 pipeline: the write side of the 16-bit instruction memory port the core fetches from. Receives a framed program image over a valid/ready byte interface (fed by a UART receiver or a host bridge), assembles big-endian 16-bit instruction words and writes them to consecutive IMEM addresses starting at 0. Holds the core in reset via `cpu_hold` until a complete frame with a correct checksum has been loaded.

---
 rtl/imem_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader that frames, checksums and writes big-endian 16-bit words
// into instruction memory, holding the core in reset until a good frame lands.
module imem_loader #(
   parameter int         ADDR_W = 10,
   parameter logic [7:0] HDR    = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA_HI, S_DATA_LO,
      S_WRITE, S_CHECK, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

   state_t              state_r;
   logic [7:0]          cnt_lo_r;
   logic [15:0]         cnt_r;
   logic [7:0]          hi_r;
   logic [7:0]          chk_r;
   logic [ADDR_W-1:0]   addr_r;
   logic                xfer_s;
   logic [15:0]         n_s;
   logic [ADDR_W:0]     wc_next_s;

   function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   assign xfer_s    = in_valid & in_ready;
   assign n_s       = {in_data, cnt_lo_r};
   assign wc_next_s = word_count + {{ADDR_W{1'b0}}, 1'b1};

   // Frame parser, checksum accumulator and registered IMEM write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_IDLE;
         cnt_lo_r   <= 8'd0;
         cnt_r      <= 16'd0;
         hi_r       <= 8'd0;
         chk_r      <= 8'd0;
         addr_r     <= '0;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 16'd0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         word_count <= '0;
      end else begin
         imem_we  <= 1'b0;
         in_ready <= 1'b1;
         case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
               if (xfer_s && (in_data == HDR)) begin
                  state_r    <= S_CNT_LO;
                  load_done  <= 1'b0;
                  load_err   <= 1'b0;
                  word_count <= '0;
                  chk_r      <= 8'd0;
                  addr_r     <= '0;
                  cpu_hold   <= 1'b1;
               end
            end
            S_CNT_LO: begin
               if (xfer_s) begin
                  cnt_lo_r <= in_data;
                  chk_r    <= chk_next(chk_r, in_data);
                  state_r  <= S_CNT_HI;
               end
            end
            S_CNT_HI: begin
               if (xfer_s) begin
                  cnt_r <= n_s;
                  chk_r <= chk_next(chk_r, in_data);
                  if ({1'b0, n_s} > MAX_N) begin
                     state_r  <= S_ERR;
                     load_err <= 1'b1;
                  end else if (n_s == 16'd0) begin
                     state_r <= S_CHECK;
                  end else begin
                     state_r <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (xfer_s) begin
                  hi_r    <= in_data;
                  chk_r   <= chk_next(chk_r, in_data);
                  state_r <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (xfer_s) begin
                  chk_r      <= chk_next(chk_r, in_data);
                  imem_we    <= 1'b1;
                  imem_addr  <= addr_r;
                  imem_wdata <= {hi_r, in_data};
                  in_ready   <= 1'b0;
                  state_r    <= S_WRITE;
               end
            end
            S_WRITE: begin
               addr_r     <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               word_count <= wc_next_s;
               if (17'(wc_next_s) < {1'b0, cnt_r}) begin
                  state_r <= S_DATA_HI;
               end else begin
                  state_r <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (xfer_s) begin
                  if (in_data == chk_r) begin
                     state_r   <= S_DONE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     state_r  <= S_ERR;
                     load_err <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule
